// File: rtl/fg_morph_filter_if.sv
// Pixel stream into the morphological filter and the filtered, window-centred stream out of it.
interface fg_morph_filter_if;
  logic        vid_active_pix;
  logic [10:0] vid_hpos;
  logic [10:0] vid_vpos;
  logic        fg_raw;
  logic        foregnd_px;
  logic        out_valid;
  logic [10:0] out_hpos;
  logic [10:0] out_vpos;

  modport master (
    output vid_active_pix, vid_hpos, vid_vpos, fg_raw,
    input  foregnd_px, out_valid, out_hpos, out_vpos
  );

  modport slave (
    input  vid_active_pix, vid_hpos, vid_vpos, fg_raw,
    output foregnd_px, out_valid, out_hpos, out_vpos
  );
endinterface

// File: rtl/fg_morph_filter.sv
// 3x3 population-threshold filter on a 1-bit foreground mask, one-cycle latency.
// Optional macro FG_FILTER_STATS_EN adds a per-frame foreground pixel count on fg_count.
module fg_morph_filter #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int THRESH = 5
) (
  input  logic              app_clk,
  input  logic              app_rst_n,
  fg_morph_filter_if.slave  vid,
  output logic [18:0]       fg_count
);

  localparam int         AW  = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam logic [3:0] THR = 4'(THRESH);

  logic [H_RES-1:0] buf1;
  logic [H_RES-1:0] buf2;
  logic [1:0]       win0_p0, win1_p0, win2_p0;
  logic [AW-1:0]    addr;
  logic             tap1, tap2;
  logic             active, line_start, edge_col, edge_row;
  logic             vld_p0, fg_p0;
  logic [3:0]       sum0_p0, sum1_p0, sum2_p0, sum_p0;

  function automatic logic [3:0] pop3(input logic a, input logic b, input logic c);
    return {3'b000, a} + {3'b000, b} + {3'b000, c};
  endfunction

  function automatic logic at_thresh(input logic [3:0] sum);
    return sum >= THR;
  endfunction

  assign active     = vid.vid_active_pix && (vid.vid_hpos < 11'(H_RES)) && (vid.vid_vpos < 11'(V_RES));
  assign addr       = vid.vid_hpos[AW-1:0];
  assign tap1       = buf1[addr];
  assign tap2       = buf2[addr];
  assign line_start = (vid.vid_hpos == 11'd0);
  assign edge_col   = (vid.vid_hpos == 11'd1);
  assign edge_row   = (vid.vid_vpos == 11'd1);
  assign vld_p0     = active && (vid.vid_hpos != 11'd0) && (vid.vid_vpos != 11'd0);

  // Stage p0: window columns x, x-1, x-2; out-of-frame taps forced to zero
  assign sum0_p0 = pop3(vid.fg_raw, win0_p0[0], win0_p0[1] && !edge_col);
  assign sum1_p0 = pop3(tap1,       win1_p0[0], win1_p0[1] && !edge_col);
  assign sum2_p0 = edge_row ? 4'd0 : pop3(tap2, win2_p0[0], win2_p0[1] && !edge_col);
  assign sum_p0  = sum0_p0 + sum1_p0 + sum2_p0;
  assign fg_p0   = at_thresh(sum_p0);

  always_ff @(posedge app_clk) begin
    if (active) begin
      buf1[addr] <= vid.fg_raw;
      buf2[addr] <= tap1;
    end
  end

  // At column 0 the older stage is dropped so nothing leaks from the previous line
  always_ff @(posedge app_clk or negedge app_rst_n) begin
    if (!app_rst_n) begin
      win0_p0 <= '0;
      win1_p0 <= '0;
      win2_p0 <= '0;
    end else if (active) begin
      win0_p0 <= {win0_p0[0] && !line_start, vid.fg_raw};
      win1_p0 <= {win1_p0[0] && !line_start, tap1};
      win2_p0 <= {win2_p0[0] && !line_start, tap2};
    end
  end

  // Stage p1: registered outputs; positions hold while no window is emitted
  always_ff @(posedge app_clk or negedge app_rst_n) begin
    if (!app_rst_n) begin
      vid.out_valid  <= 1'b0;
      vid.foregnd_px <= 1'b0;
      vid.out_hpos   <= '0;
      vid.out_vpos   <= '0;
    end else begin
      vid.out_valid  <= vld_p0;
      vid.foregnd_px <= vld_p0 && fg_p0;
      if (vld_p0) begin
        vid.out_hpos <= vid.vid_hpos - 11'd1;
        vid.out_vpos <= vid.vid_vpos - 11'd1;
      end
    end
  end

`ifdef FG_FILTER_STATS_EN
  localparam logic [10:0] X_LAST = 11'(H_RES - 1);
  localparam logic [10:0] Y_LAST = 11'(V_RES - 1);

  logic [18:0] cnt;
  logic [18:0] cnt_next;
  logic        frame_ok;

  // Counted at input time; same total as counting emitted foreground outputs
  assign cnt_next = cnt + 19'(vld_p0 && fg_p0);

  always_ff @(posedge app_clk or negedge app_rst_n) begin
    if (!app_rst_n) begin
      cnt      <= '0;
      frame_ok <= 1'b0;
      fg_count <= '0;
    end else if (active) begin
      if (line_start && vid.vid_vpos == 11'd0) begin
        cnt      <= '0;
        frame_ok <= 1'b1;
      end else begin
        cnt <= cnt_next;
        if (vid.vid_hpos == X_LAST && vid.vid_vpos == Y_LAST) begin
          if (frame_ok) fg_count <= cnt_next;
          frame_ok <= 1'b0;
        end
      end
    end
  end
`else
  assign fg_count = '0;
`endif

endmodule

// File: doc/fg_morph_filter.md
FG_MORPH_FILTER -- requirements
Module: fg_morph_filter

Interface
REQ-001 Parameter H_RES, default 640: active pixels per line.
REQ-002 Parameter V_RES, default 480: active lines per frame.
REQ-003 Parameter THRESH, default 5: minimum 3x3 window population (1..9) for a foreground output.
REQ-004 app_clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 app_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 vid_active_pix  in  1  input pixel qualifier; one raw pixel per asserted cycle.
REQ-007 vid_hpos  in  11  column of the input pixel, 0..H_RES-1.
REQ-008 vid_vpos  in  11  line of the input pixel, 0..V_RES-1.
REQ-009 fg_raw  in  1  raw (unfiltered) foreground bit of the input pixel.
REQ-010 foregnd_px  out  1  filtered foreground bit; feeds blob_analyzer foregnd_px.
REQ-011 out_valid  out  1  foregnd_px, out_hpos and out_vpos are valid this cycle.
REQ-012 out_hpos  out  11  column of the output (window-centre) pixel.
REQ-013 out_vpos  out  11  line of the output (window-centre) pixel.
REQ-014 fg_count  out  19  foreground-pixel count of the last completed frame (FG_FILTER_STATS_EN only).

Function
REQ-015 The block shall hold two 1-bit line buffers of H_RES entries each; on an active pixel at column x, buf1[x] shall take fg_raw and buf2[x] shall take the old buf1[x].
REQ-016 The block shall form a 3x3 window from three 2-stage shift registers fed by fg_raw, buf1[x] (old) and buf2[x] (old), for lines y, y-1 and y-2.
REQ-017 An active input at (x,y) shall evaluate the window centred on (x-1,y-1).
REQ-018 Window taps outside the frame (column x-2<0 when x==1; line y-2<0 when y==1) shall read as 0, whatever the buffer contents.
REQ-019 Window sum shall be a 4-bit unsigned value, 0..9; foregnd_px = (sum >= THRESH).
REQ-020 Latency shall be exactly 1 app_clk: outputs are registered on the edge after the input sample.
REQ-021 out_valid shall assert only for inputs with x>=1 and y>=1; centres in column H_RES-1 and line V_RES-1 are never emitted and are background by definition.
REQ-022 When out_valid is low, foregnd_px shall be 0 and out_hpos/out_vpos shall hold their last values.
REQ-023 Cycles with vid_active_pix low shall not shift the window, write the buffers or change the counters; blanking of any length shall be tolerated.
REQ-024 The row shift registers shall be cleared when an active pixel arrives with x==0, so that no taps carry over from the previous line.

Reset
REQ-025 While app_rst_n is low: foregnd_px=0, out_valid=0, out_hpos=0, out_vpos=0, shift registers=0, fg_count=0.
REQ-026 Line buffers shall not be reset; REQ-018 masking makes their contents irrelevant for the first two lines.
REQ-027 Reset asserted mid-frame shall abort the frame: no fg_count update, and output resumes per REQ-021 from the next input pixel.

Configuration
REQ-028 With macro FG_FILTER_STATS_EN defined, an internal 19-bit counter shall increment on every cycle with out_valid=1 and foregnd_px=1.
REQ-029 That counter shall clear on an active input at (0,0), and its value shall be copied to fg_count on the active input at (H_RES-1,V_RES-1), including that pixel's own contribution.
REQ-030 Without FG_FILTER_STATS_EN, the fg_count port shall be tied to 0 and the counter logic shall be absent.

Verification
REQ-031 All fg_raw=0 for a full 640x480 frame with 150-cycle line blanking -> foregnd_px never 1; out_valid asserted 639*479 times.
REQ-032 Rectangle fg_raw=1 for x 21..200, y 6..99, THRESH=9 -> output 1 exactly for x 22..199, y 7..98 (erosion).
REQ-033 Single isolated fg_raw=1 at (300,200), THRESH=1 -> output 1 at centres x 299..301, y 199..201; 0 elsewhere.
REQ-034 Full frame all 1s, THRESH=5 -> (0,0) output 0 (sum 4); (1,0) output 1 (sum 6); (1,1) output 1 (sum 9).
REQ-035 FG_FILTER_STATS_EN, REQ-032 stimulus for two frames -> fg_count=0 until first frame end, then 178*92=16376.
REQ-036 app_rst_n pulsed low at (320,240) -> outputs 0 within the reset; fg_count unchanged at 0; next full frame is correct.
